// File: rtl/core_alu_pipe.sv
// Pipelined two-operand ALU with tag sideband; result latency is STAGES cycles.
// Backpressure: all stages freeze while the last stage holds an unaccepted result.
module core_alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [3:0]       flags_o,
    output logic             illegal_o
);
    localparam int MSB = WIDTH - 1;
    localparam int SW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_PASSA = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;

    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   ext;
    logic             c_f, v_f, ill, z_f;
    logic [SW-1:0]    sh;
    logic             big;
    logic             lt_s, lt_u;
    logic             advance;

    assign sh   = b_i[SW-1:0];
    assign big  = (b_i >= WIDTH_V);
    assign lt_s = ($signed(a_i) < $signed(b_i));
    assign lt_u = (a_i < b_i);

    // Shifts run on a one-bit-extended operand so the last bit shifted out
    // lands in the extension bit; a zero shift leaves that bit clear.
    always_comb begin
        res = '0;
        ext = '0;
        c_f = 1'b0;
        v_f = 1'b0;
        ill = 1'b0;
        case (op_i)
            OP_ADD: begin
                ext = {1'b0, a_i} + {1'b0, b_i};
                res = ext[MSB:0];
                c_f = ext[WIDTH];
                v_f = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                ext = {1'b0, a_i} - {1'b0, b_i};
                res = ext[MSB:0];
                c_f = ext[WIDTH];
                v_f = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
            end
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_SHL: begin
                if (!big) begin
                    ext = {1'b0, a_i} << sh;
                    res = ext[MSB:0];
                    c_f = ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (!big) begin
                    ext = {a_i, 1'b0} >> sh;
                    res = ext[WIDTH:1];
                    c_f = ext[0];
                end
            end
            OP_SRA: begin
                if (big) begin
                    res = {WIDTH{a_i[MSB]}};
                end else begin
                    ext = $signed({a_i, 1'b0}) >>> sh;
                    res = ext[WIDTH:1];
                    c_f = ext[0];
                end
            end
            OP_PASSA: res = a_i;
            OP_PASSB: res = b_i;
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, lt_u};
            default:  ill = 1'b1;
        endcase
    end

    assign z_f = ~ill & (res == '0);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] ill_q;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [3:0]        flg_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];

    assign advance    = out_ready_i | ~vld_q[STAGES-1];
    assign in_ready_o = advance;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            ill_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid_i;
            ill_q[0] <= ill;
            res_q[0] <= res;
            flg_q[0] <= {z_f, res[MSB], c_f, v_f};
            tag_q[0] <= tag_i;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                ill_q[i] <= ill_q[i-1];
                res_q[i] <= res_q[i-1];
                flg_q[i] <= flg_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[STAGES-1];
    assign illegal_o   = ill_q[STAGES-1];
    assign result_o    = res_q[STAGES-1];
    assign flags_o     = flg_q[STAGES-1];
    assign tag_o       = tag_q[STAGES-1];
endmodule

// File: tb/tb_core_alu_pipe.sv
// Randomised and directed bench for core_alu_pipe against an arithmetic reference model.
module tb_core_alu_pipe;
    localparam int WIDTH  = 16;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [3:0]       op_i = 4'd0;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [WIDTH-1:0] result_o;
    logic [TAG_W-1:0] tag_o;
    logic [3:0]       flags_o;
    logic             illegal_o;

    core_alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .tag_o(tag_o), .flags_o(flags_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  f;
        logic        ill;
        logic [3:0]  tag;
    } exp_t;

    int tests = 0;
    int fails = 0;

    logic [3:0]  seq_op [8];
    logic [15:0] seq_a [8];
    logic [15:0] seq_b [8];
    logic [3:0]  seq_tag [8];
    int          iss_cyc [8];
    exp_t        obs [8];
    int          obs_cyc [8];
    int          obs_n;

    // Reference: plain integer arithmetic on 16-bit values, flags packed {Z,N,C,V}.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] tag);
        exp_t e;
        int ai = int'(a);
        int bi = int'(b);
        int sa = (ai >= 32768) ? ai - 65536 : ai;
        int sb = (bi >= 32768) ? bi - 65536 : bi;
        int r = 0;
        int c = 0;
        int v = 0;
        int ill = 0;
        case (int'(op))
            0: begin r = ai + bi; c = (r > 65535) ? 1 : 0;
                     v = (sa + sb > 32767 || sa + sb < -32768) ? 1 : 0; end
            1: begin r = ai - bi; c = (ai < bi) ? 1 : 0;
                     v = (sa - sb > 32767 || sa - sb < -32768) ? 1 : 0; end
            2: r = ai & bi;
            3: r = ai | bi;
            4: r = ai ^ bi;
            5: if (bi < 16) begin r = ai << bi; c = (bi > 0) ? (ai >> (16 - bi)) & 1 : 0; end
            6: if (bi < 16) begin r = ai >> bi; c = (bi > 0) ? (ai >> (bi - 1)) & 1 : 0; end
            7: if (bi < 16) begin r = sa >>> bi; c = (bi > 0) ? (ai >> (bi - 1)) & 1 : 0; end
               else r = (sa < 0) ? -1 : 0;
            8: r = ai;
            9: r = bi;
            10: r = (sa < sb) ? 1 : 0;
            11: r = (ai < bi) ? 1 : 0;
            default: ill = 1;
        endcase
        r = r & 32'h0000_FFFF;
        e.r   = r[15:0];
        e.f   = {(r == 0 && ill == 0), r[15], c[0], v[0]};
        e.ill = ill[0];
        e.tag = tag;
        return e;
    endfunction

    task automatic cycle(input logic rst, input logic iv, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] tg, input logic ordy);
        @(negedge clk);
        rst_i = rst; in_valid_i = iv; op_i = op; a_i = a; b_i = b; tag_i = tg; out_ready_i = ordy;
        #1;
    endtask

    task automatic run_seq(input int n);
        int i = 0;
        obs_n = 0;
        for (int k = 0; k < n + 20 && obs_n < n; k++) begin
            if (i < n) cycle(1'b0, 1'b1, seq_op[i], seq_a[i], seq_b[i], seq_tag[i], 1'b1);
            else       cycle(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 1'b1);
            if (out_valid_o && obs_n < 8) begin
                obs[obs_n] = {result_o, flags_o, illegal_o, tag_o};
                obs_cyc[obs_n] = k;
                obs_n++;
            end
            if (i < n && in_ready_o) begin iss_cyc[i] = k; i++; end
        end
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 1'b1);
        cycle(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 1'b1);
        cycle(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 1'b1);
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        tests++; if ({result_o, flags_o, illegal_o, tag_o} !== 25'd0) begin fails++;
            $display("FAIL reset_payload got r=%h f=%b i=%b t=%h exp=0", result_o, flags_o, illegal_o, tag_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
    endtask

    task automatic test_add_latency;
        seq_op[0] = 4'd0; seq_a[0] = 16'h7FFF; seq_b[0] = 16'h0001; seq_tag[0] = 4'd3;
        run_seq(1);
        tests++; if (obs_n !== 1) begin fails++; $display("FAIL add_count got=%0d exp=1", obs_n); end
        tests++; if (obs_cyc[0] - iss_cyc[0] !== STAGES) begin fails++;
            $display("FAIL add_latency got=%0d exp=%0d", obs_cyc[0] - iss_cyc[0], STAGES); end
        tests++; if (obs[0] !== {16'h8000, 4'b0101, 1'b0, 4'd3}) begin fails++;
            $display("FAIL add_result got=%h exp=%h", obs[0], {16'h8000, 4'b0101, 1'b0, 4'd3}); end
    endtask

    task automatic test_back_to_back;
        seq_op[0] = 4'd1;  seq_a[0] = 16'h0000; seq_b[0] = 16'h0001; seq_tag[0] = 4'd1;
        seq_op[1] = 4'd10; seq_a[1] = 16'hFFFF; seq_b[1] = 16'h0001; seq_tag[1] = 4'd2;
        run_seq(2);
        tests++; if (obs[0] !== {16'hFFFF, 4'b0110, 1'b0, 4'd1}) begin fails++;
            $display("FAIL b2b_sub got=%h exp=%h", obs[0], {16'hFFFF, 4'b0110, 1'b0, 4'd1}); end
        tests++; if (obs[1] !== {16'h0001, 4'b0000, 1'b0, 4'd2}) begin fails++;
            $display("FAIL b2b_slt got=%h exp=%h", obs[1], {16'h0001, 4'b0000, 1'b0, 4'd2}); end
        tests++; if (obs_n !== 2 || obs_cyc[1] !== obs_cyc[0] + 1) begin fails++;
            $display("FAIL b2b_consecutive got n=%0d c0=%0d c1=%0d exp consecutive", obs_n, obs_cyc[0], obs_cyc[1]); end
    endtask

    task automatic test_shifts;
        seq_op[0] = 4'd7; seq_a[0] = 16'h8000; seq_b[0] = 16'd20; seq_tag[0] = 4'd4;
        seq_op[1] = 4'd5; seq_a[1] = 16'h0001; seq_b[1] = 16'd16; seq_tag[1] = 4'd5;
        seq_op[2] = 4'd6; seq_a[2] = 16'h8001; seq_b[2] = 16'd1;  seq_tag[2] = 4'd6;
        run_seq(3);
        tests++; if (obs[0] !== {16'hFFFF, 4'b0100, 1'b0, 4'd4}) begin fails++;
            $display("FAIL sra_big got=%h exp=%h", obs[0], {16'hFFFF, 4'b0100, 1'b0, 4'd4}); end
        tests++; if (obs[1] !== {16'h0000, 4'b1000, 1'b0, 4'd5}) begin fails++;
            $display("FAIL shl_big got=%h exp=%h", obs[1], {16'h0000, 4'b1000, 1'b0, 4'd5}); end
        tests++; if (obs[2] !== {16'h4000, 4'b0010, 1'b0, 4'd6}) begin fails++;
            $display("FAIL shr_one got=%h exp=%h", obs[2], {16'h4000, 4'b0010, 1'b0, 4'd6}); end
    endtask

    task automatic test_illegal;
        seq_op[0] = 4'd13; seq_a[0] = 16'h1234; seq_b[0] = 16'h0000; seq_tag[0] = 4'd9;
        run_seq(1);
        tests++; if (obs_n !== 1 || obs_cyc[0] - iss_cyc[0] !== STAGES) begin fails++;
            $display("FAIL illegal_latency got n=%0d lat=%0d exp=%0d", obs_n, obs_cyc[0] - iss_cyc[0], STAGES); end
        tests++; if (obs[0] !== {16'h0000, 4'b0000, 1'b1, 4'd9}) begin fails++;
            $display("FAIL illegal_result got=%h exp=%h", obs[0], {16'h0000, 4'b0000, 1'b1, 4'd9}); end
    endtask

    task automatic test_backpressure;
        exp_t q[$];
        exp_t got;
        int acc = 0;
        int last = -1;
        int gap_bad = 0;
        logic taken = 1'b0;
        logic iv;
        logic [3:0] p_op = 4'($urandom_range(0, 11));
        logic [15:0] p_a = 16'($urandom);
        logic [15:0] p_b = 16'($urandom_range(0, 20));
        logic [3:0] p_tag = 4'($urandom);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, p_op, p_a, p_b, p_tag, 1'b0);
            if (!in_ready_o) break;
            q.push_back(model(p_op, p_a, p_b, p_tag));
            acc++;
            p_op = 4'($urandom_range(0, 11)); p_a = 16'($urandom);
            p_b = 16'($urandom_range(0, 20)); p_tag = 4'($urandom);
        end
        tests++; if (acc !== STAGES) begin fails++; $display("FAIL bp_fill got=%0d exp=%0d", acc, STAGES); end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, p_op, p_a, p_b, p_tag, 1'b0);
            got = {result_o, flags_o, illegal_o, tag_o};
            tests++; if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || q.size() == 0 || got !== q[0]) begin
                fails++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b vld=%b data=%h exp rdy=0 vld=1 data=%h",
                         k, in_ready_o, out_valid_o, got, (q.size() > 0) ? q[0] : '0);
            end
        end
        for (int k = 0; k < 20 && (q.size() > 0 || !taken); k++) begin
            iv = ~taken;
            cycle(1'b0, iv, p_op, p_a, p_b, p_tag, 1'b1);
            if (out_valid_o) begin
                got = {result_o, flags_o, illegal_o, tag_o};
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL bp_drain_extra got=%h exp none", got); end
                else if (got !== q[0]) begin fails++; $display("FAIL bp_drain got=%h exp=%h", got, q[0]); end
                if (q.size() > 0) void'(q.pop_front());
                if (last >= 0 && k != last + 1) gap_bad++;
                last = k;
            end
            if (iv && in_ready_o) begin q.push_back(model(p_op, p_a, p_b, p_tag)); taken = 1'b1; end
        end
        tests++; if (q.size() !== 0 || gap_bad !== 0) begin fails++;
            $display("FAIL bp_drain_order got left=%0d gaps=%0d exp 0 0", q.size(), gap_bad); end
    endtask

    task automatic test_reset_midflight;
        int seen = 0;
        exp_t e;
        cycle(1'b0, 1'b1, 4'd0, 16'h0102, 16'h0304, 4'd5, 1'b1);
        cycle(1'b0, 1'b1, 4'd1, 16'h0500, 16'h0006, 4'd6, 1'b1);
        cycle(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 1'b1);
        tests++; if ({out_valid_o, result_o, flags_o, illegal_o, tag_o} !== 26'd0) begin fails++;
            $display("FAIL midrst_clear got v=%b r=%h f=%b i=%b t=%h exp all 0",
                     out_valid_o, result_o, flags_o, illegal_o, tag_o); end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0, 1'b1);
            if (out_valid_o) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_ghost got=%0d exp=0", seen); end
        seq_op[0] = 4'd4; seq_a[0] = 16'hA5A5; seq_b[0] = 16'h0FF0; seq_tag[0] = 4'd12;
        e = model(4'd4, 16'hA5A5, 16'h0FF0, 4'd12);
        run_seq(1);
        tests++; if (obs_n !== 1 || obs[0] !== e) begin fails++;
            $display("FAIL midrst_after got n=%0d data=%h exp n=1 data=%h", obs_n, obs[0], e); end
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t got;
        logic iv, ordy;
        logic [3:0] op, tg;
        logic [15:0] a, b;
        for (int k = 0; k < 400; k++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 3) != 0) || (k >= 380);
            if (k >= 380) iv = 1'b0;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: a = 16'h8000;
                1: a = 16'h7FFF;
                default: a = 16'($urandom);
            endcase
            b  = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
            tg = 4'($urandom);
            cycle(1'b0, iv, op, a, b, tg, ordy);
            if (out_valid_o && out_ready_i) begin
                got = {result_o, flags_o, illegal_o, tag_o};
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL rand_extra cyc=%0d got=%h exp none", k, got); end
                else begin
                    if (got !== q[0]) begin fails++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", k, got, q[0]); end
                    void'(q.pop_front());
                end
            end
            if (in_valid_i && in_ready_o) q.push_back(model(op, a, b, tg));
        end
        tests++; if (q.size() !== 0) begin fails++; $display("FAIL rand_lost got=%0d exp=0", q.size()); end
    endtask

    initial begin
        test_reset;
        test_add_latency;
        test_back_to_back;
        test_shifts;
        test_illegal;
        test_backpressure;
        test_reset_midflight;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
